// File: rtl/trapezoid_if.sv
// trapezoid_if: sample stream, segment pulse and frame-total handshake of the trapezoid integrator.
interface trapezoid_if #(
    parameter int DATA_W     = 16,
    parameter int STEP_SHIFT = 3,
    parameter int ACC_W      = 40
);
    logic                         s_valid;
    logic                         s_ready;
    logic [DATA_W-1:0]            s_data;
    logic [DATA_W+STEP_SHIFT:0]   seg_area;
    logic                         seg_valid;
    logic                         m_valid;
    logic                         m_ready;
    logic [ACC_W-1:0]             m_sum;
    logic                         m_overflow;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, seg_area, seg_valid, m_valid, m_sum, m_overflow
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, seg_area, seg_valid, m_valid, m_sum, m_overflow
    );
endinterface

// File: rtl/trapezoid_integrator.sv
// trapezoid_integrator: sums (prev + cur) << STEP_SHIFT over FRAME_LEN samples and holds the frame total.
// Define TRAP_SAT_EN to make the accumulator saturate instead of wrapping.
module trapezoid_integrator #(
    parameter int DATA_W     = 16,
    parameter int STEP_SHIFT = 3,
    parameter int FRAME_LEN  = 64,
    parameter int ACC_W      = 40
) (
    input logic         clk,
    input logic         rst,
    trapezoid_if.slave  bus
);
    localparam int AREA_W = DATA_W + STEP_SHIFT + 1;
    localparam int CNT_W  = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {FIRST, ACCUM, HOLD} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   prev;
    logic [CNT_W-1:0]    cnt;
    logic [ACC_W-1:0]    acc, acc_nx, m_sum;
    logic                sticky, m_valid, m_overflow, seg_valid;
    logic [AREA_W-1:0]   area, seg_area;
    logic [DATA_W:0]     pair;
    logic [ACC_W:0]      sum_full;
    logic                accept, take, last, ovf;

    assign accept   = bus.s_valid && bus.s_ready;
    assign take     = m_valid && bus.m_ready;
    assign last     = cnt == CNT_W'(FRAME_LEN - 1);
    assign pair     = {1'b0, prev} + {1'b0, bus.s_data};
    assign area     = AREA_W'(pair) << STEP_SHIFT;
    assign sum_full = {1'b0, acc} + {{(ACC_W + 1 - AREA_W){1'b0}}, area};
    assign ovf      = sum_full[ACC_W];
`ifdef TRAP_SAT_EN
    assign acc_nx   = ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign acc_nx   = sum_full[ACC_W-1:0];
`endif

    assign bus.s_ready    = state != HOLD;
    assign bus.seg_area   = seg_area;
    assign bus.seg_valid  = seg_valid;
    assign bus.m_valid    = m_valid;
    assign bus.m_sum      = m_sum;
    assign bus.m_overflow = m_overflow;

    always_comb begin
        state_nx = (state == FIRST && accept)         ? ACCUM :
                   (state == ACCUM && accept && last) ? HOLD  :
                   (state == HOLD && take)            ? FIRST : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FIRST;
            prev       <= '0;
            cnt        <= '0;
            acc        <= '0;
            sticky     <= 1'b0;
            seg_area   <= '0;
            seg_valid  <= 1'b0;
            m_valid    <= 1'b0;
            m_sum      <= '0;
            m_overflow <= 1'b0;
        end else begin
            state     <= state_nx;
            seg_valid <= accept && state == ACCUM;
            if (accept && state == FIRST) begin
                prev <= bus.s_data;
                cnt  <= CNT_W'(1);
            end
            if (accept && state == ACCUM) begin
                seg_area <= area;
                acc      <= acc_nx;
                sticky   <= sticky | ovf;
                prev     <= bus.s_data;
                cnt      <= cnt + CNT_W'(1);
                if (last) begin
                    m_sum      <= acc_nx;
                    m_overflow <= sticky | ovf;
                    m_valid    <= 1'b1;
                end
            end
            // the handshake only happens in HOLD, so it never collides with an accept
            if (take) begin
                m_valid <= 1'b0;
                acc     <= '0;
                cnt     <= '0;
                sticky  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trapezoid_integrator.sv
// tb_trapezoid_integrator: directed per-cycle vectors on a 40-bit build plus a 21-bit overflow instance.
module tb_trapezoid_integrator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    trapezoid_if #(.DATA_W(16), .STEP_SHIFT(3), .ACC_W(40)) b1 ();
    trapezoid_if #(.DATA_W(16), .STEP_SHIFT(3), .ACC_W(21)) b2 ();

    trapezoid_integrator #(.DATA_W(16), .STEP_SHIFT(3), .FRAME_LEN(4), .ACC_W(40)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    trapezoid_integrator #(.DATA_W(16), .STEP_SHIFT(3), .FRAME_LEN(4), .ACC_W(21)) dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct packed {
        logic        sv;
        logic [15:0] sd;
        logic        mr;
        logic        e_segv;
        logic [19:0] e_seg;
        logic        e_mv;
        logic [39:0] e_sum;
        logic        e_sr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic sv, logic [15:0] sd, logic mr, logic segv, logic [19:0] seg,
                               logic mv, logic [39:0] sum, logic sr);
        return '{sv, sd, mr, segv, seg, mv, sum, sr};
    endfunction

    task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step1(logic sv, logic [15:0] sd, logic mr);
        b1.s_valid = sv;
        b1.s_data  = sd;
        b1.m_ready = mr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step2(logic sv, logic [15:0] sd, logic mr);
        b2.s_valid = sv;
        b2.s_data  = sd;
        b2.m_ready = mr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset1(string tag);
        chk({tag, " s_ready"}, 40'(b1.s_ready), 40'd1);
        chk({tag, " seg_valid"}, 40'(b1.seg_valid), 40'd0);
        chk({tag, " seg_area"}, 40'(b1.seg_area), 40'd0);
        chk({tag, " m_valid"}, 40'(b1.m_valid), 40'd0);
        chk({tag, " m_sum"}, b1.m_sum, 40'd0);
        chk({tag, " m_overflow"}, 40'(b1.m_overflow), 40'd0);
    endtask

    initial begin
        // basic frame, m_ready held high
        vecs.push_back(v(1, 10, 1, 0, 0,      0, 0, 1));
        vecs.push_back(v(1, 20, 1, 1, 240,    0, 0, 1));
        vecs.push_back(v(1, 30, 1, 1, 400,    0, 0, 1));
        vecs.push_back(v(1, 40, 1, 1, 560,    1, 1200, 0));
        vecs.push_back(v(0, 0,  1, 0, 0,      0, 1200, 1));
        vecs.push_back(v(0, 0,  1, 0, 0,      0, 1200, 1));
        // same frame with the consumer stalling
        vecs.push_back(v(1, 10, 0, 0, 0,      0, 1200, 1));
        vecs.push_back(v(1, 20, 0, 1, 240,    0, 1200, 1));
        vecs.push_back(v(1, 30, 0, 1, 400,    0, 1200, 1));
        vecs.push_back(v(1, 40, 0, 1, 560,    1, 1200, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(v(1, 1, 0, 0, 0, 1, 1200, 0));
        vecs.push_back(v(1, 1, 1, 0, 0,       0, 1200, 1));
        vecs.push_back(v(1, 1, 1, 0, 0,       0, 1200, 1));
        vecs.push_back(v(1, 1, 1, 1, 16,      0, 1200, 1));
        vecs.push_back(v(1, 1, 1, 1, 16,      0, 1200, 1));
        vecs.push_back(v(1, 1, 1, 1, 16,      1, 48, 0));
        vecs.push_back(v(0, 0, 1, 0, 0,       0, 48, 1));
        // full-scale samples
        vecs.push_back(v(1, 16'hffff, 1, 0, 0,       0, 48, 1));
        vecs.push_back(v(1, 16'hffff, 1, 1, 1048560, 0, 48, 1));
        vecs.push_back(v(1, 16'hffff, 1, 1, 1048560, 0, 48, 1));
        vecs.push_back(v(1, 16'hffff, 1, 1, 1048560, 1, 3145680, 0));
        vecs.push_back(v(0, 0, 1, 0, 0,       0, 3145680, 1));
        // gapped input
        vecs.push_back(v(1, 5,  1, 0, 0,      0, 3145680, 1));
        vecs.push_back(v(0, 5,  1, 0, 0,      0, 3145680, 1));
        vecs.push_back(v(1, 7,  1, 1, 96,     0, 3145680, 1));
        vecs.push_back(v(0, 7,  1, 0, 0,      0, 3145680, 1));
        vecs.push_back(v(1, 9,  1, 1, 128,    0, 3145680, 1));
        vecs.push_back(v(0, 9,  1, 0, 0,      0, 3145680, 1));
        vecs.push_back(v(1, 11, 1, 1, 160,    1, 384, 0));
        vecs.push_back(v(0, 0,  1, 0, 0,      0, 384, 1));

        b1.s_valid = 0; b1.s_data = 0; b1.m_ready = 0;
        b2.s_valid = 0; b2.s_data = 0; b2.m_ready = 0;
        repeat (2) @(negedge clk);
        chk_reset1("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            step1(vecs[i].sv, vecs[i].sd, vecs[i].mr);
            chk($sformatf("v%0d seg_valid", i), 40'(b1.seg_valid), 40'(vecs[i].e_segv));
            if (vecs[i].e_segv) chk($sformatf("v%0d seg_area", i), 40'(b1.seg_area), 40'(vecs[i].e_seg));
            chk($sformatf("v%0d m_valid", i), 40'(b1.m_valid), 40'(vecs[i].e_mv));
            chk($sformatf("v%0d m_sum", i), b1.m_sum, vecs[i].e_sum);
            chk($sformatf("v%0d m_overflow", i), 40'(b1.m_overflow), 40'd0);
            chk($sformatf("v%0d s_ready", i), 40'(b1.s_ready), 40'(vecs[i].e_sr));
        end
        step1(0, 0, 0);

        // asynchronous reset in the middle of a frame
        step1(1, 100, 1);
        step1(1, 200, 1);
        chk("mid seg_area", 40'(b1.seg_area), 40'd2400);
        #2 rst = 1'b1;
        #1 chk_reset1("async");
        @(negedge clk);
        rst = 1'b0;
        step1(1, 1, 1);
        chk("post seg_valid", 40'(b1.seg_valid), 40'd0);
        step1(1, 2, 1);
        chk("post seg1", 40'(b1.seg_area), 40'd24);
        step1(1, 3, 1);
        chk("post seg2", 40'(b1.seg_area), 40'd40);
        chk("post m_valid early", 40'(b1.m_valid), 40'd0);
        step1(1, 4, 1);
        chk("post seg3", 40'(b1.seg_area), 40'd56);
        chk("post m_valid", 40'(b1.m_valid), 40'd1);
        chk("post m_sum", b1.m_sum, 40'd120);
        step1(0, 0, 1);
        chk("post taken", 40'(b1.m_valid), 40'd0);

        // 21-bit accumulator overflow
        for (int i = 0; i < 4; i++) step2(1, 16'hffff, 1);
        chk("ovf m_valid", 40'(b2.m_valid), 40'd1);
`ifdef TRAP_SAT_EN
        chk("ovf m_sum", b2.m_sum, 40'd2097151);
`else
        chk("ovf m_sum", b2.m_sum, 40'd1048528);
`endif
        chk("ovf m_overflow", 40'(b2.m_overflow), 40'd1);
        chk("ovf seg_area", 40'(b2.seg_area), 40'd1048560);
        step2(0, 0, 1);
        for (int i = 0; i < 4; i++) step2(1, 1, 1);
        chk("ovf2 m_sum", b2.m_sum, 40'd48);
        chk("ovf2 m_overflow", 40'(b2.m_overflow), 40'd0);
        step2(0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
